key_cmd_sched: RTL
==================

KEY_CMD_SCHED -- requirements
Module: key_cmd_sched

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning command FIFO depth in entries (power of 2, 2..16).
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port key_flag  input  4  one-cycle debounced-edge pulse per key i.
REQ-005 The block SHALL have port key_state  input  4  debounced key level per key i; 0 = pressed.
REQ-006 The block SHALL have port cmd_valid  output  1  FIFO head holds a command.
REQ-007 The block SHALL have port cmd_id  output  2  command code at FIFO head; code = key index (0 INC, 1 DEC, 2 CLR, 3 LOAD).
REQ-008 The block SHALL have port cmd_ready  input  1  downstream LED datapath accepts head command.
REQ-009 The block SHALL have port fifo_cnt  output  5  entries currently held, 0..DEPTH.
REQ-010 The block SHALL have port drop_pulse  output  1  one-cycle pulse when a press event is discarded.
REQ-011 The block SHALL have port drop_cnt  output  8  saturating count of discarded press events.

Function
REQ-012 A press event on key i SHALL be key_flag[i]=1 and key_state[i]=0 in the same cycle; release edges (key_state[i]=1) SHALL be ignored.
REQ-013 Each key SHALL have a registered pending bit, set in the cycle after its press event.
REQ-014 A press on key i whose pending bit is set and not granted that cycle SHALL be discarded: drop_pulse=1 next cycle, drop_cnt +1, saturating at 255.
REQ-015 A press on key i in the cycle its pending bit is granted SHALL leave pending[i] set; no drop.
REQ-016 Arbiter: each cycle, if any pending bit is set and FIFO can accept a write, exactly one key SHALL be granted, its index pushed to the FIFO, its pending bit cleared.
REQ-017 Grant SHALL be round-robin: first pending index searching upward from rr_ptr, wrapping 3->0; after a grant rr_ptr = (grant+1) mod 4; rr_ptr unchanged with no grant.
REQ-018 FIFO can accept a write when fifo_cnt < DEPTH, or when fifo_cnt = DEPTH and a pop occurs the same cycle.
REQ-019 Pop SHALL occur when cmd_valid=1 and cmd_ready=1; cmd_id SHALL advance to next entry the following cycle.
REQ-020 cmd_valid SHALL equal (fifo_cnt != 0) and SHALL be driven from registers only; cmd_id SHALL be stable while cmd_valid=1 and cmd_ready=0.
REQ-021 Simultaneous push and pop SHALL leave fifo_cnt unchanged; FIFO order SHALL be strict first-in-first-out.
REQ-022 With FIFO full and no pop, pending bits SHALL hold (no grant, no drop); presses on already-pending keys still drop per REQ-014.
REQ-023 Latency: press at cycle T into empty FIFO, no competing pending, SHALL give cmd_valid=1 with that cmd_id at cycle T+2.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; fifo_cnt SHALL never exceed DEPTH nor underflow.

Reset
REQ-025 While rst=1: pending=0, rr_ptr=0, FIFO empty, fifo_cnt=0, cmd_valid=0, cmd_id=0, drop_pulse=0, drop_cnt=0.
REQ-026 Reset asserted mid-operation SHALL discard all pending and queued commands immediately, asynchronously to clk.
REQ-027 Inputs SHALL be ignored during reset; first press event is recognised in the first clock edge after rst deasserts.

Verification
REQ-028 Single press key1 at T, cmd_ready=1 -> cmd_valid=1, cmd_id=1 at T+2 for one cycle; fifo_cnt returns to 0.
REQ-029 Presses on keys 0,2,3 same cycle, cmd_ready=1, rr_ptr=1 -> pushed order 2,3,0; rr_ptr ends 1.
REQ-030 cmd_ready=0, five distinct-cycle presses on keys 0,1,2,3,0 (DEPTH=4) -> fifo_cnt=4, pending[0]=1, no drop; raise cmd_ready -> output 0,1,2,3,0.
REQ-031 Key0 pending with FIFO full, second key0 press -> drop_pulse one cycle, drop_cnt=1; 300 such drops -> drop_cnt=255.
REQ-032 FIFO full, pending key2, cmd_ready=1 for one cycle -> pop and push same cycle, fifo_cnt stays 4, pending[2] cleared.
REQ-033 rst=1 asserted between clock edges with fifo_cnt=3 -> cmd_valid=0, fifo_cnt=0, drop_cnt=0 without waiting for clk.

Source files
------------

// File: rtl/key_cmd_sched.sv
// rtl/key_cmd_sched.sv - key press to command scheduler with round-robin arbiter and command FIFO
module key_cmd_sched #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_flag,
    input  logic [3:0] key_state,
    output logic       cmd_valid,
    output logic [1:0] cmd_id,
    input  logic       cmd_ready,
    output logic [4:0] fifo_cnt,
    output logic       drop_pulse,
    output logic [7:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [3:0]    pending;
    logic [1:0]    rr_ptr;
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    cnt;
    logic          valid_q;

    logic [3:0]    press;
    logic          pop;
    logic          can_write;
    logic          gnt_any;
    logic [1:0]    gnt_idx;
    logic [3:0]    gnt_vec;
    logic [3:0]    drop_vec;
    logic [2:0]    drop_n;
    logic [8:0]    drop_sum;
    logic [4:0]    cnt_next;

    // Press events are falling edges only; a flag with the key released is ignored.
    assign press     = key_flag & ~key_state;
    assign pop       = valid_q & cmd_ready;
    assign can_write = (cnt < DEPTH_C) || pop;

    assign cmd_valid = valid_q;
    assign cmd_id    = mem[rd_ptr];
    assign fifo_cnt  = cnt;

    // Round-robin search upward from rr_ptr; grant is suppressed when the FIFO cannot take a write.
    always_comb begin : rr_arb
        logic [1:0] cand;
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!gnt_any && pending[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (!can_write) begin
            gnt_any = 1'b0;
        end
        gnt_vec = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;
    end

    // A press only drops when its key is still pending after this cycle's grant.
    always_comb begin
        drop_vec = press & pending & ~gnt_vec;
        drop_n   = {2'b00, drop_vec[0]} + {2'b00, drop_vec[1]}
                 + {2'b00, drop_vec[2]} + {2'b00, drop_vec[3]};
        drop_sum = {1'b0, drop_cnt} + {6'b000000, drop_n};
    end

    // Next occupancy: a simultaneous push and pop cancel out.
    always_comb begin
        cnt_next = cnt;
        if (gnt_any && !pop) begin
            cnt_next = cnt + 5'd1;
        end else if (!gnt_any && pop) begin
            cnt_next = cnt - 5'd1;
        end
    end

    // Pending bits and round-robin pointer; a press in the grant cycle re-arms the key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 4'd0;
            rr_ptr  <= 2'd0;
        end else begin
            pending <= (pending & ~gnt_vec) | press;
            if (gnt_any) begin
                rr_ptr <= gnt_idx + 2'd1;
            end
        end
    end

    // Command FIFO storage, pointers and registered valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 2'd0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= 5'd0;
            valid_q <= 1'b0;
        end else begin
            if (gnt_any) begin
                mem[wr_ptr] <= gnt_idx;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt     <= cnt_next;
            valid_q <= (cnt_next != 5'd0);
        end
    end

    // Drop pulse and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            drop_pulse <= |drop_vec;
            drop_cnt   <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

endmodule
